// File: rtl/bullet_wave_scheduler.sv
// Bullet slot sequencer: spawns, sweeps down-screen, clears on hit/exit, ends the wave.
// Optional BULLET_SPEEDUP_EN: per-sweep step grows with the wave's tick count (capped at 15).
module bullet_wave_scheduler #(
  parameter int unsigned SLOTS      = 3,
  parameter int unsigned Y_LIMIT    = 200,
  parameter int unsigned Y_RESET    = 1,
  parameter int unsigned STEP       = 5,
  parameter int unsigned WAVE_TICKS = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        isRun,
  input  logic        tick,
  input  logic        isCollide,
  input  logic [2:0]  hitIndex,
  output logic        wrEn,
  output logic [2:0]  wrIndex,
  output logic [35:0] wrData,
  output logic        busy,
  output logic        waveDone,
  output logic        tickOverrun
);

  localparam int unsigned IW  = 3;
  localparam int unsigned SIW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CW  = $clog2(WAVE_TICKS + 1);
  localparam logic [IW:0] SLOTS_W = (IW + 1)'(SLOTS);
  localparam logic [7:0]  SPAWN_Y = 8'd19;

  typedef struct packed {
    logic       render;
    logic [2:0] color;
    logic [7:0] size_x;
    logic [7:0] size_y;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
  } bullet_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_SWEEP, S_FIX, S_CLEAR, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SLOTS-1:0] render_q, render_d;
  logic [SLOTS-1:0] pend_q, pend_d;
  logic [7:0]       pos_y_q [SLOTS];
  logic [7:0]       pos_y_d [SLOTS];
  logic             wr_en_q, wr_en_d;
  logic [IW-1:0]    wr_idx_q, wr_idx_d;
  bullet_t          wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             wave_done_q, wave_done_d;
  logic             tick_ovr_q, tick_ovr_d;

  logic             hit_ok;
  logic [SIW-1:0]   fix_idx;
  logic [7:0]       step_c;
  logic [7:0]       cur_y;
  logic [7:0]       new_y;
  logic             last_slot;

  // Constant spawn fields; slots repeat the 3-entry pattern (only slot kind 1 differs).
  function automatic bullet_t rom_word(input logic [IW-1:0] idx, input logic render,
                                       input logic [7:0] pos_y);
    bullet_t b;
    b.render = render;
    b.pos_y  = pos_y;
    case (idx)
      3'd1, 3'd4, 3'd7: begin
        b.color = 3'b001; b.size_x = 8'd100; b.size_y = 8'd100; b.pos_x = 8'd56;
      end
      default: begin
        b.color = 3'b010; b.size_x = 8'd16;  b.size_y = 8'd16;  b.pos_x = 8'd160;
      end
    endcase
    return b;
  endfunction

`ifdef BULLET_SPEEDUP_EN
  logic [8:0] boost;
  always_comb begin
    boost  = 9'(STEP) + 9'(cnt_q >> 6);
    step_c = (boost > 9'd15) ? 8'd15 : 8'(boost);
  end
`else
  always_comb step_c = 8'(STEP);
`endif

  // Lowest slot whose post-sweep clear write is still owed.
  always_comb begin
    fix_idx = '0;
    for (int i = int'(SLOTS) - 1; i >= 0; i--) begin
      if (pend_q[i]) fix_idx = SIW'(i);
    end
  end

  always_comb begin
    hit_ok    = isCollide && ({1'b0, hitIndex} < SLOTS_W) &&
                (state_q inside {S_RUN, S_SWEEP, S_FIX});
    last_slot = (idx_q == IW'(SLOTS - 1));
    cur_y     = pos_y_q[SIW'(idx_q)];
    new_y     = (cur_y >= 8'(Y_LIMIT)) ? 8'(Y_RESET) : cur_y + step_c;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    render_d   = render_q;
    pend_d     = pend_q;
    pos_y_d    = pos_y_q;
    wr_en_d    = 1'b0;
    wr_idx_d   = '0;
    wr_data_d  = '0;
    tick_ovr_d = tick && (state_q != S_RUN);

    if (hit_ok) render_d[SIW'(hitIndex)] = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (isRun) begin
          state_d = S_LOAD;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        wr_en_d  = 1'b1;
        wr_idx_d = idx_q;
        wr_data_d = rom_word(idx_q, 1'b1, SPAWN_Y);
        render_d[SIW'(idx_q)] = 1'b1;
        pos_y_d[SIW'(idx_q)]  = SPAWN_Y;
        if (last_slot) begin
          idx_d   = '0;
          state_d = isRun ? S_RUN : S_CLEAR;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_RUN: begin
        if (hit_ok) begin
          wr_en_d   = 1'b1;
          wr_idx_d  = hitIndex;
          wr_data_d = rom_word(hitIndex, 1'b0, pos_y_q[SIW'(hitIndex)]);
        end
        if (!isRun) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if ((cnt_q >= CW'(WAVE_TICKS)) || (render_q == '0)) begin
          state_d = S_DONE;
        end else if (tick) begin
          state_d = S_SWEEP;
          idx_d   = '0;
          cnt_d   = cnt_q + CW'(1);
          pend_d  = '0;
        end
      end
      S_SWEEP: begin
        // A same-cycle hit on this slot folds into its step write.
        wr_en_d   = 1'b1;
        wr_idx_d  = idx_q;
        wr_data_d = rom_word(idx_q,
                             render_q[SIW'(idx_q)] & ~(hit_ok && (hitIndex == idx_q)),
                             new_y);
        pos_y_d[SIW'(idx_q)] = new_y;
        if (hit_ok && (hitIndex < idx_q)) pend_d[SIW'(hitIndex)] = 1'b1;
        if (last_slot) begin
          idx_d = '0;
          if (pend_d != '0)  state_d = S_FIX;
          else if (!isRun)   state_d = S_CLEAR;
          else               state_d = S_RUN;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_FIX: begin
        wr_en_d   = 1'b1;
        wr_idx_d  = IW'(fix_idx);
        wr_data_d = rom_word(IW'(fix_idx), 1'b0, pos_y_q[fix_idx]);
        pend_d[fix_idx] = 1'b0;
        if (hit_ok && (SIW'(hitIndex) != fix_idx)) pend_d[SIW'(hitIndex)] = 1'b1;
        if (pend_d == '0) state_d = isRun ? S_RUN : S_CLEAR;
      end
      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_idx_d  = idx_q;
        wr_data_d = rom_word(idx_q, 1'b0, cur_y);
        render_d[SIW'(idx_q)] = 1'b0;
        if (last_slot) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (!isRun) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = state_d inside {S_LOAD, S_SWEEP, S_FIX, S_CLEAR};
    wave_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      render_q    <= '0;
      pend_q      <= '0;
      for (int i = 0; i < int'(SLOTS); i++) pos_y_q[i] <= '0;
      wr_en_q     <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      wave_done_q <= 1'b0;
      tick_ovr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      render_q    <= render_d;
      pend_q      <= pend_d;
      pos_y_q     <= pos_y_d;
      wr_en_q     <= wr_en_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      wave_done_q <= wave_done_d;
      tick_ovr_q  <= tick_ovr_d;
    end
  end

  assign wrEn        = wr_en_q;
  assign wrIndex     = wr_idx_q;
  assign wrData      = wr_data_q;
  assign busy        = busy_q;
  assign waveDone    = wave_done_q;
  assign tickOverrun = tick_ovr_q;

endmodule
